mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (instruction/data cache) arbiter in front of a single memory port.
// One transaction in flight; turn alternates after every completed transaction.
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int READ_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [ADDR_BITS-1:0]     ic_req_addr,
  input  logic                     ic_req_rw,
  input  logic                     ic_req_data_valid,
  output logic                     ic_req_data_ready,
  input  logic [DATA_BITS-1:0]     ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   ic_req_data_mask,
  output logic                     ic_resp_valid,
  output logic [DATA_BITS-1:0]     ic_resp_data,

  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic [ADDR_BITS-1:0]     dc_req_addr,
  input  logic                     dc_req_rw,
  input  logic                     dc_req_data_valid,
  output logic                     dc_req_data_ready,
  input  logic [DATA_BITS-1:0]     dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   dc_req_data_mask,
  output logic                     dc_resp_valid,
  output logic [DATA_BITS-1:0]     dc_resp_data,

  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [DATA_BITS-1:0]     mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [DATA_BITS-1:0]     mem_resp_data,

  output logic                     resp_err
);

  localparam int CNT_BITS = $clog2(READ_BEATS);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t              state_q, state_d;
  logic                turn_q, turn_d;
  logic                owner_q, owner_d;
  logic [CNT_BITS-1:0] beat_q, beat_d;
  logic                resp_err_q, resp_err_d;

  logic run;
  logic is_idle, is_read, is_write;
  logic turn_valid, other_valid, turn_rw;
  logic own_data_valid;
  logic accept, data_hs, last_beat;

  // Outputs are forced low while reset is held, even before the state flops settle.
  assign run      = reset;
  assign is_idle  = (state_q == ST_IDLE);
  assign is_read  = (state_q == ST_READ);
  assign is_write = (state_q == ST_WRITE);

  assign turn_valid     = (turn_q == OWN_DC) ? dc_req_valid : ic_req_valid;
  assign other_valid    = (turn_q == OWN_DC) ? ic_req_valid : dc_req_valid;
  assign turn_rw        = (turn_q == OWN_DC) ? dc_req_rw    : ic_req_rw;
  assign own_data_valid = (owner_q == OWN_DC) ? dc_req_data_valid : ic_req_data_valid;

  assign mem_req_valid      = run & is_idle & turn_valid;
  assign mem_req_addr       = (turn_q == OWN_DC) ? dc_req_addr : ic_req_addr;
  assign mem_req_rw         = turn_rw;
  assign mem_req_data_valid = run & is_write & own_data_valid;
  assign mem_req_data_bits  = (owner_q == OWN_DC) ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = (owner_q == OWN_DC) ? dc_req_data_mask : ic_req_data_mask;

  // Ready never looks at valid, so clients may gate valid on ready without a loop.
  assign ic_req_ready = run & is_idle & (turn_q == OWN_IC) & mem_req_ready;
  assign dc_req_ready = run & is_idle & (turn_q == OWN_DC) & mem_req_ready;

  assign ic_req_data_ready = run & is_write & (owner_q == OWN_IC) & mem_req_data_ready;
  assign dc_req_data_ready = run & is_write & (owner_q == OWN_DC) & mem_req_data_ready;

  assign ic_resp_valid = run & is_read & (owner_q == OWN_IC) & mem_resp_valid;
  assign dc_resp_valid = run & is_read & (owner_q == OWN_DC) & mem_resp_valid;
  assign ic_resp_data  = run ? mem_resp_data : '0;
  assign dc_resp_data  = run ? mem_resp_data : '0;

  assign resp_err = resp_err_q;

  assign accept    = mem_req_valid & mem_req_ready;
  assign data_hs   = mem_req_data_valid & mem_req_data_ready;
  assign last_beat = (beat_q == CNT_BITS'(READ_BEATS - 1));

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    owner_d    = owner_q;
    beat_d     = beat_q;
    // Any beat arriving outside a read is dropped and latched as an error.
    resp_err_d = resp_err_q | (mem_resp_valid & ~is_read);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = turn_q;
          state_d = turn_rw ? ST_WRITE : ST_READ;
        end else if (!turn_valid && other_valid) begin
          turn_d = ~turn_q;
        end
      end
      ST_READ: begin
        if (mem_resp_valid) begin
          beat_d = beat_q + CNT_BITS'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            turn_d  = ~owner_q;
          end
        end
      end
      ST_WRITE: begin
        if (data_hs) begin
          state_d = ST_IDLE;
          turn_d  = ~owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      turn_q     <= OWN_DC;
      owner_q    <= OWN_DC;
      beat_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read/write arbitration, turn flip, stray beats, reset.
module tb_mem_arbiter;
  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [AB-1:0] ic_req_addr;
  logic [DB-1:0] ic_req_data_bits, ic_resp_data;
  logic [MB-1:0] ic_req_data_mask;
  logic          ic_resp_valid;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [AB-1:0] dc_req_addr;
  logic [DB-1:0] dc_req_data_bits, dc_resp_data;
  logic [MB-1:0] dc_req_data_mask;
  logic          dc_resp_valid;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives n response beats base, base+1, ... and checks they reach only the owner.
  task automatic read_beats(input logic to_dc, input logic [127:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 128'(i);
      #1;
      chk("beat_dc_valid", dc_resp_valid, to_dc);
      chk("beat_ic_valid", ic_resp_valid, !to_dc);
      chk("beat_data", to_dc ? dc_resp_data : ic_resp_data, base + 128'(i));
      chk("beat_ic_ready", ic_req_ready, 1'b0);
      chk("beat_dc_ready", dc_req_ready, 1'b0);
      cycle();
    end
    mem_resp_valid = 1'b0;
    $display("txn read owner=%s beats=%0d base=%0h", to_dc ? "dc" : "ic", n, base);
  endtask

  initial begin
    reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 28'h100; ic_req_rw = 1'b0;
    ic_req_data_valid = 1'b0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 1'b1; dc_req_addr = 28'h40; dc_req_rw = 1'b0;
    dc_req_data_valid = 1'b0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    cycle();
    cycle();
    chk("rst_dc_ready", dc_req_ready, 1'b0);
    chk("rst_ic_ready", ic_req_ready, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);

    // Both clients valid from reset: dc first, ic after its four beats.
    reset = 1'b1;
    #1;
    chk("p1_dc_ready", dc_req_ready, 1'b1);
    chk("p1_ic_ready", ic_req_ready, 1'b0);
    chk("p1_mem_valid", mem_req_valid, 1'b1);
    chk("p1_mem_addr", mem_req_addr, 28'h40);
    chk("p1_mem_rw", mem_req_rw, 1'b0);
    cycle();
    dc_req_valid = 1'b0;
    #1;
    chk("p1_read_mem_valid", mem_req_valid, 1'b0);
    chk("p1_read_ic_ready", ic_req_ready, 1'b0);
    read_beats(1'b1, 128'hA, 4);
    #1;
    chk("p1_after_ic_ready", ic_req_ready, 1'b1);
    chk("p1_after_dc_ready", dc_req_ready, 1'b0);
    chk("p1_ic_addr", mem_req_addr, 28'h100);
    chk("p1_ic_mem_valid", mem_req_valid, 1'b1);
    cycle();
    ic_req_valid = 1'b0;
    read_beats(1'b0, 128'h20, 4);

    // Only ic valid while turn is dc: one dead cycle, then accept.
    ic_req_valid = 1'b1; ic_req_addr = 28'h200;
    #1;
    chk("flip_ic_ready_before", ic_req_ready, 1'b0);
    chk("flip_mem_valid_before", mem_req_valid, 1'b0);
    cycle();
    chk("flip_ic_ready_after", ic_req_ready, 1'b1);
    chk("flip_mem_valid_after", mem_req_valid, 1'b1);
    chk("flip_mem_addr", mem_req_addr, 28'h200);
    cycle();
    ic_req_valid = 1'b0;
    read_beats(1'b0, 128'h30, 4);

    // dc write, data_ready held low for three cycles.
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h80;
    dc_req_data_valid = 1'b1;
    dc_req_data_bits = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    dc_req_data_mask = 16'h000F;
    #1;
    chk("wr_mem_rw", mem_req_rw, 1'b1);
    chk("wr_idle_data_valid", mem_req_data_valid, 1'b0);
    chk("wr_idle_data_ready", dc_req_data_ready, 1'b0);
    cycle();
    dc_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_data_valid", mem_req_data_valid, 1'b1);
      chk("wr_data_bits", mem_req_data_bits, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      chk("wr_data_mask", mem_req_data_mask, 16'h000F);
      chk("wr_dc_data_ready_wait", dc_req_data_ready, 1'b0);
      cycle();
    end
    mem_req_data_ready = 1'b1;
    #1;
    chk("wr_dc_data_ready", dc_req_data_ready, 1'b1);
    chk("wr_ic_data_ready", ic_req_data_ready, 1'b0);
    cycle();
    mem_req_data_ready = 1'b0;
    chk("wr_after_data_valid", mem_req_data_valid, 1'b0);
    chk("wr_after_ic_ready", ic_req_ready, 1'b1);
    chk("wr_after_no_resp", dc_resp_valid, 1'b0);
    dc_req_data_valid = 1'b0; dc_req_rw = 1'b0;
    $display("txn write owner=dc addr=80 mask=000f");

    // Stray beat in IDLE: dropped, sticky error.
    mem_resp_valid = 1'b1; mem_resp_data = 128'hEE;
    #1;
    chk("stray_ic_valid", ic_resp_valid, 1'b0);
    chk("stray_dc_valid", dc_resp_valid, 1'b0);
    cycle();
    mem_resp_valid = 1'b0;
    chk("stray_err_set", resp_err, 1'b1);
    cycle();
    cycle();
    chk("stray_err_sticky", resp_err, 1'b1);
    reset = 1'b0;
    cycle();
    chk("stray_err_cleared", resp_err, 1'b0);
    reset = 1'b1;
    $display("txn stray beat in idle");

    // Reset after beat 2 of a dc read.
    dc_req_valid = 1'b1; dc_req_addr = 28'h40;
    #1;
    chk("mid_dc_ready", dc_req_ready, 1'b1);
    cycle();
    dc_req_valid = 1'b0;
    read_beats(1'b1, 128'h50, 2);
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 128'h99;
    #1;
    chk("mid_rst_dc_valid", dc_resp_valid, 1'b0);
    chk("mid_rst_dc_data", dc_resp_data, 128'h0);
    chk("mid_rst_mem_valid", mem_req_valid, 1'b0);
    chk("mid_rst_dc_ready", dc_req_ready, 1'b0);
    cycle();
    chk("mid_rst_err_held", resp_err, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_post_dc_valid", dc_resp_valid, 1'b0);
    cycle();
    mem_resp_valid = 1'b0;
    chk("mid_post_err", resp_err, 1'b1);
    dc_req_valid = 1'b1; dc_req_addr = 28'h60;
    #1;
    chk("mid_next_dc_ready", dc_req_ready, 1'b1);
    chk("mid_next_addr", mem_req_addr, 28'h60);
    cycle();
    dc_req_valid = 1'b0;
    read_beats(1'b1, 128'h70, 4);
    chk("mid_next_turn_ic", ic_req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
